// File: rtl/csr_wb_arbiter_if.sv
// Write-port bundle around csr_wb_arbiter: core and math write inputs,
// merged CSR-file write output and FIFO status.
interface csr_wb_arbiter_if #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 24
);
    logic                     iw_core_wen;
    logic [ADDR_W-1:0]        iw_core_waddr;
    logic [DATA_W-1:0]        iw_core_wdata;
    logic                     iw_math_wen;
    logic [ADDR_W-1:0]        iw_math_waddr;
    logic [DATA_W-1:0]        iw_math_wdata;
    logic                     iw_ovf_clr;
    logic                     ow_csr_wen;
    logic [ADDR_W-1:0]        ow_csr_waddr;
    logic [DATA_W-1:0]        ow_csr_wdata;
    logic                     ow_math_pending;
    logic [$clog2(DEPTH):0]   ow_fifo_level;
    logic                     ow_ovf;

    // Side that drives writes in and observes the merged port.
    modport master (
        output iw_core_wen, iw_core_waddr, iw_core_wdata,
        output iw_math_wen, iw_math_waddr, iw_math_wdata, iw_ovf_clr,
        input  ow_csr_wen, ow_csr_waddr, ow_csr_wdata,
        input  ow_math_pending, ow_fifo_level, ow_ovf
    );

    // The arbiter itself.
    modport slave (
        input  iw_core_wen, iw_core_waddr, iw_core_wdata,
        input  iw_math_wen, iw_math_waddr, iw_math_wdata, iw_ovf_clr,
        output ow_csr_wen, ow_csr_waddr, ow_csr_wdata,
        output ow_math_pending, ow_fifo_level, ow_ovf
    );
endinterface

// File: rtl/csr_wb_arbiter.sv
// csr_wb_arbiter: merges the core CSR write port with the math24_async
// write-back port onto one registered CSR-file write port. Core writes
// always win; math writes queue in an ordered FIFO and drain when the core
// is idle, bypassing the FIFO when it is empty.
module csr_wb_arbiter #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 24
) (
    input  logic             iw_clk,
    input  logic             iw_rst,
    csr_wb_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t              mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] level;

    logic             empty;
    logic             full;
    logic             do_core;
    logic             do_pop;
    logic             do_bypass;
    logic             do_push;
    logic             drop;

    // Per-cycle source selection and FIFO push/pop/drop decisions.
    always_comb begin
        empty     = (level == '0);
        full      = (level == LVL_W'(DEPTH));
        do_core   = bus.iw_core_wen;
        do_pop    = !bus.iw_core_wen && !empty;
        do_bypass = !bus.iw_core_wen && empty && bus.iw_math_wen;
        // A popping cycle frees a slot, so a full FIFO still accepts the push.
        do_push   = bus.iw_math_wen && !do_bypass && (!full || do_pop);
        drop      = bus.iw_math_wen && full && !do_pop;
    end

    // FIFO storage; stale contents are harmless since level gates every read.
    always_ff @(posedge iw_clk) begin
        if (!iw_rst && do_push)
            mem[wr_ptr] <= '{addr: bus.iw_math_waddr, data: bus.iw_math_wdata};
    end

    // FIFO pointers (wrap modulo DEPTH) and explicit occupancy counter.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Output register: core, then FIFO head, then bypass; addr/data hold when idle.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            bus.ow_csr_wen   <= 1'b0;
            bus.ow_csr_waddr <= '0;
            bus.ow_csr_wdata <= '0;
        end else if (do_core) begin
            bus.ow_csr_wen   <= 1'b1;
            bus.ow_csr_waddr <= bus.iw_core_waddr;
            bus.ow_csr_wdata <= bus.iw_core_wdata;
        end else if (do_pop) begin
            bus.ow_csr_wen   <= 1'b1;
            bus.ow_csr_waddr <= mem[rd_ptr].addr;
            bus.ow_csr_wdata <= mem[rd_ptr].data;
        end else if (do_bypass) begin
            bus.ow_csr_wen   <= 1'b1;
            bus.ow_csr_waddr <= bus.iw_math_waddr;
            bus.ow_csr_wdata <= bus.iw_math_wdata;
        end else begin
            bus.ow_csr_wen   <= 1'b0;
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge iw_clk) begin
        if (iw_rst)              bus.ow_ovf <= 1'b0;
        else if (drop)           bus.ow_ovf <= 1'b1;
        else if (bus.iw_ovf_clr) bus.ow_ovf <= 1'b0;
    end

    assign bus.ow_fifo_level   = level;
    assign bus.ow_math_pending = (level != '0);
endmodule
